// File: rtl/pose_grid_sched.sv
// pose_grid_sched: walks every mass point of one arm pose through the
// pose2grid pipeline under a credit limit and reports a collide/free verdict.
module pose_grid_sched #(
    parameter int STEPPERS_NUM = 6,
    parameter int MASS_NUM     = 1250,
    parameter int MASS_AW      = 11,
    parameter int OUT_MAX      = 8
) (
    input  logic                         CLK,
    input  logic                         RST_n,
    input  logic                         poseValid,
    output logic                         poseReady,
    input  logic [32*STEPPERS_NUM-1:0]   stepperPosition,
    output logic [32*STEPPERS_NUM-1:0]   convPose,
    output logic                         convStart,
    output logic                         massValid,
    output logic [1:0]                   massPart,
    output logic [MASS_AW-1:0]           massIdx,
    input  logic                         hitValid,
    input  logic                         hit,
    output logic                         resultValid,
    output logic                         resultCollide,
    input  logic                         resultReady,
    output logic                         busy,
    output logic                         protoErr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_DRAIN,
        S_REPORT
    } state_t;

    localparam logic [3:0]         CREDITS  = 4'(OUT_MAX);
    localparam logic [MASS_AW-1:0] LAST_IDX = MASS_AW'(MASS_NUM - 1);

    state_t                state_q;
    logic [3:0]            outst_q;
    logic [3:0]            outst_d;
    logic [1:0]            part_q;
    logic [MASS_AW-1:0]    idx_q;
    logic                  collide_q;
    logic                  perr_q;
    logic [32*STEPPERS_NUM-1:0] pose_q;

    logic issue;
    logic ret;
    logic spurious;

    // Everything visible outside is a decode of registered state only.
    assign issue         = (state_q == S_ISSUE) && (outst_q < CREDITS);
    assign ret           = hitValid && (outst_q != 4'd0);
    assign spurious      = hitValid && (outst_q == 4'd0);

    assign poseReady     = (state_q == S_IDLE);
    assign convStart     = (state_q == S_LOAD);
    assign massValid     = issue;
    assign massPart      = part_q;
    assign massIdx       = idx_q;
    assign resultValid   = (state_q == S_REPORT);
    assign resultCollide = (state_q == S_REPORT) && collide_q;
    assign busy          = (state_q != S_IDLE);
    assign protoErr      = perr_q;
    assign convPose      = pose_q;

    // Credit count: an issue and a return in one cycle cancel out.
    always_comb begin
        outst_d = outst_q;
        if (issue && !ret) begin
            outst_d = outst_q + 4'd1;
        end else if (!issue && ret) begin
            outst_d = outst_q - 4'd1;
        end
    end

    // Outstanding lookups and the sticky protocol error.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            outst_q <= 4'd0;
            perr_q  <= 1'b0;
        end else begin
            outst_q <= outst_d;
            if (spurious) begin
                perr_q <= 1'b1;
            end
        end
    end

    // Pose sequencing: latch, load trig terms, issue, drain, report.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= S_IDLE;
            pose_q    <= '0;
            part_q    <= 2'd0;
            idx_q     <= '0;
            collide_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (poseValid) begin
                        pose_q    <= stepperPosition;
                        part_q    <= 2'd0;
                        idx_q     <= '0;
                        collide_q <= 1'b0;
                        state_q   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state_q <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (issue) begin
                        if (idx_q == LAST_IDX) begin
                            if (part_q == 2'd2) begin
                                state_q <= S_DRAIN;
                            end else begin
                                idx_q  <= '0;
                                part_q <= part_q + 2'd1;
                            end
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                    // First collision ends the walk; issue above still counts.
                    if (hitValid && hit) begin
                        collide_q <= 1'b1;
                        state_q   <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (hitValid && hit) begin
                        collide_q <= 1'b1;
                    end
                    if (outst_q == 4'd0) begin
                        state_q <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    if (resultReady) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pose_grid_sched.sv
// tb_pose_grid_sched: random poses, latencies and hit patterns checked
// against a transaction-level model of credits, issue order and verdicts.
module tb_pose_grid_sched;

    localparam int SN = 6;
    localparam int MN = 4;
    localparam int AW = 3;
    localparam int OM = 4;
    localparam int NM = 3 * MN;

    logic              CLK = 1'b0;
    logic              RST_n;
    logic              poseValid;
    logic              poseReady;
    logic [32*SN-1:0]  stepperPosition;
    logic [32*SN-1:0]  convPose;
    logic              convStart;
    logic              massValid;
    logic [1:0]        massPart;
    logic [AW-1:0]     massIdx;
    logic              hitValid;
    logic              hit;
    logic              resultValid;
    logic              resultCollide;
    logic              resultReady;
    logic              busy;
    logic              protoErr;

    int   total = 0;
    int   bad   = 0;
    logic pe_exp = 1'b0;

    typedef struct {
        int   due;
        logic h;
    } ret_t;

    pose_grid_sched #(
        .STEPPERS_NUM(SN),
        .MASS_NUM(MN),
        .MASS_AW(AW),
        .OUT_MAX(OM)
    ) dut (
        .CLK(CLK),
        .RST_n(RST_n),
        .poseValid(poseValid),
        .poseReady(poseReady),
        .stepperPosition(stepperPosition),
        .convPose(convPose),
        .convStart(convStart),
        .massValid(massValid),
        .massPart(massPart),
        .massIdx(massIdx),
        .hitValid(hitValid),
        .hit(hit),
        .resultValid(resultValid),
        .resultCollide(resultCollide),
        .resultReady(resultReady),
        .busy(busy),
        .protoErr(protoErr)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [191:0] got,
                         input logic [191:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [32*SN-1:0] rnd_pose();
        logic [32*SN-1:0] p;
        for (int i = 0; i < SN; i++) p[i*32 +: 32] = $urandom;
        return p;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdy"}, poseReady, 1);
        check({tag, "_start"}, convStart, 0);
        check({tag, "_mv"}, massValid, 0);
        check({tag, "_part"}, massPart, 0);
        check({tag, "_idx"}, massIdx, 0);
        check({tag, "_rv"}, resultValid, 0);
        check({tag, "_rc"}, resultCollide, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_perr"}, protoErr, 0);
        check({tag, "_pose"}, convPose, 0);
    endtask

    // One pose end to end; the model tracks in-flight lookups and verdict.
    task automatic run_pose(input int lat, input logic [NM-1:0] hmask,
                            input int hold);
        logic [32*SN-1:0] pose;
        ret_t q[$];
        ret_t e;
        int   nxt;
        int   m;
        bit   issuing;
        bit   rv_exp;
        bit   go_rep;
        bit   coll;
        bit   hit_seen;
        bit   done;
        bit   ret;
        bit   iss;
        nxt = 0; m = 0; issuing = 1; rv_exp = 0;
        coll = 0; hit_seen = 0; done = 0;
        pose = rnd_pose();
        check("idle_rdy", poseReady, 1);
        stepperPosition = pose;
        poseValid = 1;
        @(negedge CLK);
        poseValid = 0;
        stepperPosition = rnd_pose();
        check("load_start", convStart, 1);
        check("load_pose", convPose, pose);
        check("load_busy", busy, 1);
        check("load_rdy", poseReady, 0);
        check("load_mv", massValid, 0);
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge CLK);
            hitValid = 0;
            hit = 0;
            check("perr", protoErr, pe_exp);
            check("rv", resultValid, rv_exp);
            if (rv_exp) begin
                done = 1;
            end else begin
                check("mv", massValid, issuing && m < OM);
                if (massValid) begin
                    check("part", massPart, nxt / MN);
                    check("idx", massIdx, nxt % MN);
                end
                go_rep = !issuing && m == 0;
                ret = 0;
                if (q.size() > 0 && q[0].due == c) begin
                    e = q.pop_front();
                    hitValid = 1;
                    hit = e.h;
                    ret = 1;
                    coll |= e.h;
                    if (e.h) hit_seen = 1;
                end
                iss = massValid && issuing;
                if (iss) begin
                    e.due = c + lat;
                    e.h = hmask[nxt];
                    q.push_back(e);
                    nxt++;
                end
                m = m + int'(iss) - int'(ret);
                issuing = nxt < NM && !hit_seen;
                rv_exp = go_rep;
            end
        end
        hitValid = 0;
        hit = 0;
        check("timeout", done, 1);
        if (!done) return;
        check("verdict", resultCollide, coll);
        check("rep_rdy", poseReady, 0);
        for (int h = 0; h < hold; h++) begin
            poseValid = 1'($urandom_range(0, 1));
            stepperPosition = rnd_pose();
            @(negedge CLK);
            check("hold_rv", resultValid, 1);
            check("hold_rc", resultCollide, coll);
            check("hold_rdy", poseReady, 0);
            check("hold_start", convStart, 0);
        end
        poseValid = 0;
        resultReady = 1;
        @(negedge CLK);
        resultReady = 0;
        check("post_rv", resultValid, 0);
        check("post_rdy", poseReady, 1);
        check("post_busy", busy, 0);
        @(negedge CLK);
        check("idle_start", convStart, 0);
        check("idle_rdy2", poseReady, 1);
    endtask

    initial begin
        RST_n = 0;
        poseValid = 0;
        stepperPosition = '0;
        hitValid = 0;
        hit = 0;
        resultReady = 0;
        #12;
        check_reset_outputs("rst");
        @(negedge CLK);
        RST_n = 1;
        @(negedge CLK);
        check_reset_outputs("rel");

        run_pose(3, '0, 0);
        run_pose(3, NM'(1) << 5, 10);
        run_pose(6, '0, 2);

        hitValid = 1;
        hit = 0;
        @(negedge CLK);
        hitValid = 0;
        pe_exp = 1;
        check("perr_set", protoErr, 1);
        run_pose(2, '0, 1);

        for (int i = 0; i < 8; i++) begin
            logic [NM-1:0] mk;
            mk = '0;
            if ($urandom_range(0, 2) != 0) begin
                mk = NM'(1) << $urandom_range(0, NM - 1);
                if ($urandom_range(0, 1) == 1)
                    mk |= NM'(1) << $urandom_range(0, NM - 1);
            end
            run_pose($urandom_range(1, 7), mk, $urandom_range(0, 5));
        end

        stepperPosition = rnd_pose();
        poseValid = 1;
        @(negedge CLK);
        poseValid = 0;
        repeat (4) @(negedge CLK);
        check("mid_busy", busy, 1);
        #2;
        RST_n = 0;
        #1;
        pe_exp = 0;
        check_reset_outputs("async");
        @(negedge CLK);
        RST_n = 1;
        @(negedge CLK);
        check_reset_outputs("after");
        repeat (3) begin
            @(negedge CLK);
            check("no_rv", resultValid, 0);
        end
        run_pose(3, NM'(1) << 9, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
